// File: rtl/enc_pkg.sv
// enc_pkg: shared widths, types and helpers for the 4-to-2 encoder slice.
//   ENC_IN_W / ENC_OUT_W : request vector and index widths
//   enc_in_t / enc_out_t : request vector and encoded index types
//   enc_popcount4        : number of set request lines (used by the
//                          ENCODER_ONEHOT_CHECK_EN multi-hot detector)
package enc_pkg;

  localparam int unsigned ENC_IN_W  = 4;
  localparam int unsigned ENC_OUT_W = 2;

  typedef logic [ENC_IN_W-1:0]  enc_in_t;
  typedef logic [ENC_OUT_W-1:0] enc_out_t;

  function automatic logic [2:0] enc_popcount4(input enc_in_t v);
    logic [2:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < ENC_IN_W; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/enc_prio_core.sv
// enc_prio_core: combinational priority resolver for a 4-bit request vector.
// Parameters:
//   HIGH_PRIO : 1 = highest set line wins, 0 = lowest set line wins
// Ports:
//   i_req : request vector, bit i set means line i is requesting
//   o_idx : index of the winning line (00 when no line is set)
//   o_any : at least one line is set
module enc_prio_core
  import enc_pkg::*;
#(
  parameter bit HIGH_PRIO = 1'b1
) (
  input  enc_in_t  i_req,
  output enc_out_t o_idx,
  output logic     o_any
);

  enc_out_t w_idx;

  // Scan in the direction opposite to priority so the winning line is the
  // last one to overwrite w_idx.
  always_comb begin
    w_idx = '0;
    if (HIGH_PRIO) begin
      for (int unsigned i = 0; i < ENC_IN_W; i++) begin
        if (i_req[i]) w_idx = enc_out_t'(i);
      end
    end else begin
      for (int unsigned i = ENC_IN_W; i > 0; i--) begin
        if (i_req[i-1]) w_idx = enc_out_t'(i - 1);
      end
    end
  end

  assign o_idx = w_idx;
  assign o_any = |i_req;

endmodule

// File: rtl/encoder_4to2.sv
// encoder_4to2: registered 4-to-2 priority encoder with valid flag.
// Parameters:
//   HIGH_PRIO : 1 = highest set bit wins, 0 = lowest set bit wins
//   RST_OUT   : value loaded into out on reset
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset (priority over en)
//   en    : capture enable; outputs hold while low
//   in    : 4-bit request vector
//   out   : registered index of the winning line
//   valid : registered "captured in was nonzero"
//   multi : registered "captured in had >= 2 bits set"
//           (only when ENCODER_ONEHOT_CHECK_EN is defined)
// Optional feature macro: ENCODER_ONEHOT_CHECK_EN
module encoder_4to2
  import enc_pkg::*;
#(
  parameter bit       HIGH_PRIO = 1'b1,
  parameter enc_out_t RST_OUT   = 2'b00
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  enc_in_t  in,
  output enc_out_t out,
  output logic     valid
`ifdef ENCODER_ONEHOT_CHECK_EN
  ,
  output logic     multi
`endif
);

  enc_out_t w_idx;
  logic     w_any;
  enc_out_t r_out;
  logic     r_valid;

  enc_prio_core #(
    .HIGH_PRIO(HIGH_PRIO)
  ) u_core (
    .i_req(in),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= RST_OUT;
      r_valid <= 1'b0;
    end else if (en) begin
      r_out   <= w_idx;
      r_valid <= w_any;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic w_multi;
  logic r_multi;

  assign w_multi = (enc_popcount4(in) >= 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_multi <= 1'b0;
    end else if (en) begin
      r_multi <= w_multi;
    end
  end

  assign multi = r_multi;

`ifndef SYNTHESIS
  // Multi-hot requests are legal (resolved by priority) but worth flagging.
  always_ff @(posedge clk) begin
    if (!rst && en) begin
      assert (!w_multi)
        else $warning("encoder_4to2: multi-hot capture in=%b", in);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
// tb_encoder_4to2: self-checking bench for encoder_4to2. Two instances share
// stimulus: one highest-wins with RST_OUT=00, one lowest-wins with
// RST_OUT=10. A behavioural model is compared every cycle; directed steps
// add literal expectations.
module tb_encoder_4to2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] in;
  logic [1:0] out_hi, out_lo;
  logic       valid_hi, valid_lo;
`ifdef ENCODER_ONEHOT_CHECK_EN
  logic       multi_hi, multi_lo;
`endif

  int checks = 0;
  int errors = 0;

  encoder_4to2 #(
    .HIGH_PRIO(1'b1),
    .RST_OUT  (2'b00)
  ) u_hi (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .in   (in),
    .out  (out_hi),
    .valid(valid_hi)
`ifdef ENCODER_ONEHOT_CHECK_EN
    ,
    .multi(multi_hi)
`endif
  );

  encoder_4to2 #(
    .HIGH_PRIO(1'b0),
    .RST_OUT  (2'b10)
  ) u_lo (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .in   (in),
    .out  (out_lo),
    .valid(valid_lo)
`ifdef ENCODER_ONEHOT_CHECK_EN
    ,
    .multi(multi_lo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Highest set index = floor(log2(v)); lowest set index = log2 of isolated LSB.
  function automatic int hi_index(input int v);
    return (v == 0) ? 0 : $clog2(v + 1) - 1;
  endfunction

  function automatic int lo_index(input int v);
    return (v == 0) ? 0 : $clog2(v & -v);
  endfunction

  // Behavioural model
  bit m_known = 0;
  int m_out_hi, m_out_lo, m_valid, m_multi;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_out_hi = 0;
      m_out_lo = 2;
      m_valid  = 0;
      m_multi  = 0;
      m_known  = 1;
    end else if (en === 1'b1) begin
      m_out_hi = hi_index(int'(in));
      m_out_lo = lo_index(int'(in));
      m_valid  = (in != 0) ? 1 : 0;
      m_multi  = ($countones(in) >= 2) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("model_out_hi", int'(out_hi), m_out_hi);
      check("model_out_lo", int'(out_lo), m_out_lo);
      check("model_valid_hi", int'(valid_hi), m_valid);
      check("model_valid_lo", int'(valid_lo), m_valid);
`ifdef ENCODER_ONEHOT_CHECK_EN
      check("model_multi_hi", int'(multi_hi), m_multi);
      check("model_multi_lo", int'(multi_lo), m_multi);
`endif
    end
  end

  // Drive on the falling edge, then settle 1 time unit past the rising edge.
  task automatic step(input logic [3:0] v, input logic e, input logic r);
    @(negedge clk);
    in  = v;
    en  = e;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int ehi, input int elo,
                            input int ev, input int em);
    check({nm, "_out_hi"}, int'(out_hi), ehi);
    check({nm, "_out_lo"}, int'(out_lo), elo);
    check({nm, "_valid"}, int'(valid_hi), ev);
    check({nm, "_valid_lo"}, int'(valid_lo), ev);
`ifdef ENCODER_ONEHOT_CHECK_EN
    check({nm, "_multi"}, int'(multi_hi), em);
    check({nm, "_multi_lo"}, int'(multi_lo), em);
`else
    if (em < 0) check({nm, "_multi_arg"}, em, 0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    in  = 4'b0000;

    // Reset with all lines requesting
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    expect_out("reset", 0, 2, 0, 0);

    // Release and one-hot sweep
    step(4'b0001, 1'b1, 1'b0);
    expect_out("oh0001", 0, 0, 1, 0);
    step(4'b0010, 1'b1, 1'b0);
    expect_out("oh0010", 1, 1, 1, 0);
    step(4'b0100, 1'b1, 1'b0);
    expect_out("oh0100", 2, 2, 1, 0);
    step(4'b1000, 1'b1, 1'b0);
    expect_out("oh1000", 3, 3, 1, 0);

    // Zero input then recover
    step(4'b0000, 1'b1, 1'b0);
    expect_out("zero", 0, 0, 0, 0);
    step(4'b1000, 1'b1, 1'b0);
    expect_out("after_zero", 3, 3, 1, 0);

    // Priority resolution
    step(4'b0110, 1'b1, 1'b0);
    expect_out("prio0110", 2, 1, 1, 1);
    step(4'b1111, 1'b1, 1'b0);
    expect_out("prio1111", 3, 0, 1, 1);

    // Enable hold
    step(4'b0100, 1'b1, 1'b0);
    expect_out("hold_cap", 2, 2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      expect_out("hold", 2, 2, 1, 0);
    end
    step(4'b0001, 1'b1, 1'b0);
    expect_out("hold_release", 0, 0, 1, 0);

    // Mid-sweep reset, rst beats en
    step(4'b0010, 1'b1, 1'b0);
    expect_out("mid_pre", 1, 1, 1, 0);
    step(4'b0110, 1'b1, 1'b1);
    expect_out("mid_rst", 0, 2, 0, 0);
    step(4'b0100, 1'b1, 1'b0);
    expect_out("mid_resume", 2, 2, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_4to2.md
Name:
encoder_4to2

Overview:
- Registered 4-to-2 binary encoder: converts a 4-bit one-hot request vector into a 2-bit index plus a valid flag.
- Multi-hot inputs resolve by priority, so the output is always defined.
- Sits in combinational-to-registered glue paths, e.g. arbiter grant to index, or interrupt line to vector; feeds synchronous consumers in the same clock domain.

Parameters:
- HIGH_PRIO, 1, priority direction: 1 = highest set bit wins; 0 = lowest set bit wins.
- RST_OUT, 2'b00, value loaded into out on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when low, registered outputs hold.
- in  input  4  request vector; bit i set means line i is requesting.
- out  output  2  encoded index of the winning line (registered).
- valid  output  1  high when the captured in had at least one bit set (registered).
- multi  output  1  high when the captured in had more than one bit set (registered). Present only with ENCODER_ONEHOT_CHECK_EN.

Behaviour:
- The interface uses one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, out=RST_OUT, valid=0, and multi=0 (if present). rst has priority over en.
- Latency: exactly 1 cycle. in sampled at edge N with en=1 appears on out/valid at edge N+1.
- en=0: out, valid and multi hold their previous values; in is ignored.
- One-hot encoding: 0001->00, 0010->01, 0100->10, 1000->11, with valid=1.
- Zero input: in=0000 gives out=00 and valid=0. Consumers must qualify out with valid.
- Multi-hot input with HIGH_PRIO=1: the highest set index wins (e.g. 0110->10).
- Multi-hot input with HIGH_PRIO=0: the lowest set index wins (e.g. 0110->01).
- valid=1 for any nonzero input.
- Reset asserted mid-stream: outputs clear on that edge. The first post-reset capture occurs on the first edge with rst=0 and en=1.
- X/Z on in is not supported. No handshake or backpressure.

Optional Feature:
- Macro: ENCODER_ONEHOT_CHECK_EN.
- Defined:
  - Output multi exists and is registered alongside out, same latency and en/rst rules.
  - multi=1 iff popcount(captured in) >= 2.
  - A non-synthesis assertion flags multi-hot captures.
- Undefined:
  - No multi port and no check logic.
  - Priority resolution is unchanged.

Decomposition:
- Package enc_pkg holds:
  - localparam ENC_IN_W=4 and ENC_OUT_W=2.
  - typedef enc_in_t (logic [3:0]) and enc_out_t (logic [1:0]).
  - function enc_popcount4 for the optional check.
- Sub-module enc_prio_core: purely combinational, parameterised by HIGH_PRIO, producing the next-state idx and any_set.
- The top level holds only the output registers, the en/rst muxing and the optional multi logic.

Test Plan:
- Reset: rst=1 for 2 cycles with in=1111 -> out=00, valid=0, multi=0. Release rst with in=0001, en=1 -> next edge out=00, valid=1.
- One-hot sweep, en=1: in 0001, 0010, 0100, 1000 on successive cycles -> out 00, 01, 10, 11, each one cycle later, valid=1 throughout.
- Zero input: in=0000 -> out=00, valid=0. Then in=1000 -> out=11, valid=1.
- Priority, HIGH_PRIO=1: in=0110 -> out=10; in=1111 -> out=11. With HIGH_PRIO=0, same stimulus -> out=01 and 00. With ENCODER_ONEHOT_CHECK_EN: multi=1 for both, 0 for 0100.
- Enable hold: capture 0100 (out=10), drop en, drive 0001 for 3 cycles -> out stays 10, valid stays 1. Raise en -> out=00 next edge.
- Mid-operation reset: during the one-hot sweep, assert rst for 1 cycle with en=1 -> outputs go to RST_OUT/0 on that edge, and the sweep resumes one cycle after rst deasserts.
